dsp_acc_signed_neg_edge: RTL and testbench

- Downstream consumer of the registered signed multiplier product (38-bit P) in the negative-edge DSP design set.
- Accumulates a fixed-length block of LEN valid signed products and presents the block sum with a one-cycle valid pulse.
- All state updates on the falling edge of clk.
- Forms the accumulate half of a MAC chain behind the multiplier stage.

---
 rtl/dsp_acc_signed_neg_edge.sv | 89 ++++++++
 tb/tb_dsp_acc_signed_neg_edge.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/dsp_acc_signed_neg_edge.sv
// dsp_acc_signed_neg_edge
// Block accumulator for signed multiplier products, falling-edge clocked.
// Sums LEN valid products and presents the block total on acc with a
// one-cycle acc_valid pulse. ovf reports any overflow within the block.
// Optional build macro DSP_ACC_SAT_EN: clamp the running sum on overflow
// instead of wrapping modulo 2^ACC_W.
module dsp_acc_signed_neg_edge #(
  parameter  int P_W   = 38,
  parameter  int ACC_W = 44,
  parameter  int LEN   = 16,
  localparam int CNT_W = $clog2(LEN + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [P_W-1:0]   P,
  input  logic                    p_valid,
  input  logic                    clear,
  output logic signed [ACC_W-1:0] acc,
  output logic                    acc_valid,
  output logic [CNT_W-1:0]        count,
  output logic                    busy,
  output logic                    ovf
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

`ifdef DSP_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SUM_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SUM_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  logic [ACC_W-1:0] sum;
  logic             ovf_flag;
  logic [ACC_W:0]   sum_ext;
  logic             add_ovf;
  logic [ACC_W-1:0] sum_next;

  // Widened add of running sum and sign-extended product; overflow when
  // the two top bits of the extended result disagree.
  always_comb begin
    sum_ext  = {sum[ACC_W-1], sum} + {{(ACC_W+1-P_W){P[P_W-1]}}, P};
    add_ovf  = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    sum_next = sum_ext[ACC_W-1:0];
`ifdef DSP_ACC_SAT_EN
    // Extended MSB is the true sign of the result, so it picks the rail.
    if (add_ovf) begin
      sum_next = sum_ext[ACC_W] ? SUM_MIN : SUM_MAX;
    end
`endif
  end

  // Block accumulation: clear has priority, the LEN-th product publishes.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      sum       <= '0;
      ovf_flag  <= 1'b0;
      count     <= '0;
      acc       <= '0;
      acc_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (clear) begin
        sum      <= '0;
        count    <= '0;
        ovf_flag <= 1'b0;
      end else if (p_valid) begin
        if (count == LAST) begin
          acc       <= sum_next;
          ovf       <= ovf_flag | add_ovf;
          acc_valid <= 1'b1;
          sum       <= '0;
          count     <= '0;
          ovf_flag  <= 1'b0;
        end else begin
          sum      <= sum_next;
          count    <= count + 1'b1;
          ovf_flag <= ovf_flag | add_ovf;
        end
      end
    end
  end

  // A partial block is in progress whenever the product count is nonzero.
  always_comb begin
    busy = (count != '0);
  end

endmodule

// File: tb/tb_dsp_acc_signed_neg_edge.sv
// tb_dsp_acc_signed_neg_edge
// Directed bench with three accumulator instances: default widths with
// LEN=4, a 39-bit accumulator with LEN=4 for overflow, and LEN=1.
module tb_dsp_acc_signed_neg_edge;

  logic clk;
  logic rst;

  // Instance A: P_W=38, ACC_W=44, LEN=4
  logic signed [37:0] p_a;
  logic               pv_a, clr_a;
  logic signed [43:0] acc_a;
  logic               val_a, busy_a, ovf_a;
  logic [2:0]         cnt_a;

  // Instance B: P_W=38, ACC_W=39, LEN=4
  logic signed [37:0] p_b;
  logic               pv_b, clr_b;
  logic signed [38:0] acc_b;
  logic               val_b, busy_b, ovf_b;
  logic [2:0]         cnt_b;

  // Instance C: P_W=38, ACC_W=44, LEN=1
  logic signed [37:0] p_c;
  logic               pv_c, clr_c;
  logic signed [43:0] acc_c;
  logic               val_c, busy_c, ovf_c;
  logic [0:0]         cnt_c;

  int checks = 0;
  int errors = 0;

  dsp_acc_signed_neg_edge #(.P_W(38), .ACC_W(44), .LEN(4)) u_acc_a (
    .clk(clk), .reset(rst), .P(p_a), .p_valid(pv_a), .clear(clr_a),
    .acc(acc_a), .acc_valid(val_a), .count(cnt_a), .busy(busy_a), .ovf(ovf_a)
  );

  dsp_acc_signed_neg_edge #(.P_W(38), .ACC_W(39), .LEN(4)) u_acc_b (
    .clk(clk), .reset(rst), .P(p_b), .p_valid(pv_b), .clear(clr_b),
    .acc(acc_b), .acc_valid(val_b), .count(cnt_b), .busy(busy_b), .ovf(ovf_b)
  );

  dsp_acc_signed_neg_edge #(.P_W(38), .ACC_W(44), .LEN(1)) u_acc_c (
    .clk(clk), .reset(rst), .P(p_c), .p_valid(pv_c), .clear(clr_c),
    .acc(acc_c), .acc_valid(val_c), .count(cnt_c), .busy(busy_c), .ovf(ovf_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Wait for the active (falling) edge and settle before sampling.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input longint p, input logic c);
    pv_a = v; p_a = p[37:0]; clr_a = c;
    tick();
  endtask

  task automatic drive_b(input logic v, input longint p);
    pv_b = v; p_b = p[37:0]; clr_b = 1'b0;
    tick();
  endtask

  task automatic drive_c(input logic v, input longint p);
    pv_c = v; p_c = p[37:0]; clr_c = 1'b0;
    tick();
  endtask

  task automatic check_a(input string tag, input longint e_acc, input logic e_val,
                         input int e_cnt, input logic e_busy);
    check({tag, ".acc"},   acc_a,  e_acc);
    check({tag, ".valid"}, val_a,  e_val);
    check({tag, ".count"}, cnt_a,  e_cnt);
    check({tag, ".busy"},  busy_a, e_busy);
  endtask

  // Watchdog: the directed sequence is short, so a stall means a broken bench.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    longint big;
    longint exp_b;
    rst = 1'b0;
    pv_a = 0; p_a = '0; clr_a = 0;
    pv_b = 0; p_b = '0; clr_b = 0;
    pv_c = 0; p_c = '0; clr_c = 0;

    #3;
    check_a("reset", 0, 0, 0, 0);
    check("reset.ovf", ovf_a, 0);
    #4 rst = 1'b1;

    // Four consecutive P=10: pulse on the fourth edge only.
    drive_a(1, 10, 0); check_a("blk10.e1", 0, 0, 1, 1);
    drive_a(1, 10, 0); check_a("blk10.e2", 0, 0, 2, 1);
    drive_a(1, 10, 0); check_a("blk10.e3", 0, 0, 3, 1);
    drive_a(1, 10, 0); check_a("blk10.e4", 40, 1, 0, 0);
    check("blk10.ovf", ovf_a, 0);
    drive_a(0, 0, 0);  check_a("blk10.idle", 40, 0, 0, 0);

    // Products with idle gaps: -5 + 3 - 7 + 1 = -8.
    drive_a(1, -5, 0); check_a("gap.p1", 40, 0, 1, 1);
    drive_a(0, 0, 0);  check_a("gap.i1", 40, 0, 1, 1);
    drive_a(1, 3, 0);  check_a("gap.p2", 40, 0, 2, 1);
    drive_a(0, 0, 0);  check_a("gap.i2", 40, 0, 2, 1);
    drive_a(1, -7, 0); check_a("gap.p3", 40, 0, 3, 1);
    drive_a(0, 0, 0);  check_a("gap.i3", 40, 0, 3, 1);
    drive_a(1, 1, 0);  check_a("gap.p4", -8, 1, 0, 0);

    // Clear aborts a partial block; acc holds its prior value.
    drive_a(1, 100, 0); check_a("clr.p1", -8, 0, 1, 1);
    drive_a(1, 200, 0); check_a("clr.p2", -8, 0, 2, 1);
    drive_a(0, 0, 1);   check_a("clr.abort", -8, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_a(1, 1, 0);
    drive_a(1, 1, 0);   check_a("clr.ones", 4, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive_a(1, 1, 0);
    drive_a(1, 1, 1);   check_a("clr.withlast", 4, 0, 0, 0);

    // Back-to-back blocks with no bubble: 2*4 = 8 each.
    for (int i = 0; i < 3; i++) drive_a(1, 2, 0);
    drive_a(1, 2, 0);   check_a("b2b.first", 8, 1, 0, 0);
    drive_a(1, 2, 0);   check_a("b2b.next1", 8, 0, 1, 1);
    drive_a(1, 2, 0);
    drive_a(1, 2, 0);
    drive_a(1, 5, 0);   check_a("b2b.second", 11, 1, 0, 0);

    // Asynchronous reset mid-block, between edges.
    drive_a(1, 3, 0);
    drive_a(1, 3, 0);   check_a("arst.pre", 11, 0, 2, 1);
    pv_a = 0;
    #1 rst = 1'b0;
    #1;
    check_a("arst.now", 0, 0, 0, 0);
    check("arst.ovf", ovf_a, 0);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) drive_a(1, 3, 0);
    drive_a(1, 3, 0);   check_a("arst.after", 12, 1, 0, 0);
    drive_a(0, 0, 0);

    // Overflow on a 39-bit accumulator: four copies of 2^37-1.
    big = 64'sd137438953471;
`ifdef DSP_ACC_SAT_EN
    exp_b = 64'sd274877906943;
`else
    exp_b = -64'sd4;
`endif
    for (int i = 0; i < 3; i++) drive_b(1, big);
    check("ovf.prepulse", val_b, 0);
    drive_b(1, big);
    check("ovf.acc", acc_b, exp_b);
    check("ovf.flag", ovf_b, 1);
    check("ovf.valid", val_b, 1);
    for (int i = 0; i < 3; i++) drive_b(1, 1);
    check("ovf.hold", ovf_b, 1);
    drive_b(1, 1);
    check("ovf.clean.acc", acc_b, 4);
    check("ovf.clean.flag", ovf_b, 0);
    drive_b(0, 0);

    // LEN=1: every valid product pulses with the sign-extended product.
    drive_c(1, -64'sd68719345664);
    check("len1.acc", acc_c, -64'sd68719345664);
    check("len1.valid", val_c, 1);
    check("len1.count", cnt_c, 0);
    drive_c(0, 0);
    check("len1.idle", val_c, 0);
    drive_c(1, 7);
    check("len1.acc2", acc_c, 7);
    check("len1.valid2", val_c, 1);
    drive_c(1, -1);
    check("len1.acc3", acc_c, -1);
    check("len1.valid3", val_c, 1);
    drive_c(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
